// File: rtl/va_to_pa_walker.sv
// va_to_pa_walker: Sv39/Sv48 page-table walker with a round-robin TLB.
// Optional macro VAPA_PERF_EN adds saturating tlb_hits/tlb_misses outputs.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module va_to_pa_walker #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LEVELS         = 3,
  parameter int TLB_ENTRIES    = 8,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [BUS_DATA_WIDTH-1:0] virt_addr,
  input  logic [BUS_DATA_WIDTH-1:0] ptbr,
  output logic                      done,
  output logic [BUS_DATA_WIDTH-1:0] phy_addr,
  output logic                      fault,
  output logic                      abtr_reqcyc,
  input  logic                      abtr_grant,
  output logic                      bus_busy,
  output logic                      main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  input  logic                      main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  output logic                      main_bus_respack
`ifdef VAPA_PERF_EN
  ,
  output logic [31:0]               tlb_hits,
  output logic [31:0]               tlb_misses
`endif
);

  localparam int W      = BUS_DATA_WIDTH;
  localparam int TW     = BUS_TAG_WIDTH;
  localparam int VPN_W  = 9 * LEVELS;
  localparam int PPN_W  = 44;
  localparam int IW     = $clog2(TLB_ENTRIES);
  localparam int BW     = $clog2(LINE_BEATS);
  localparam int LBYTES = LINE_BEATS * 8;
  localparam logic [TW-1:0] REQ_TAG =
    TW'((`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8));
  localparam logic [W-1:0] LINE_MASK = ~(W'(LBYTES) - W'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_ARB, S_REQ, S_WAIT, S_RESP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    pte_q, pte_d;
  logic [W-1:0]    res_q, res_d;
  logic [1:0]      lvl_q, lvl_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            flt_q, flt_d;
  logic            flushed_q;
  logic            fill;

  logic [TLB_ENTRIES-1:0] tv_q;
  logic [VPN_W-1:0]       tvpn_q [TLB_ENTRIES];
  logic [1:0]             tlvl_q [TLB_ENTRIES];
  logic [PPN_W-1:0]       tppn_q [TLB_ENTRIES];
  logic [IW-1:0]          ptr_q;

  function automatic logic [W-1:0] off_mask(input logic [1:0] l);
    return (W'(1) << (12 + 9 * int'(l))) - W'(1);
  endfunction

  function automatic logic [VPN_W-1:0] vpn_mask(input logic [1:0] l);
    return ~((VPN_W'(1) << (9 * int'(l))) - VPN_W'(1));
  endfunction

  function automatic logic [W-1:0] mk_pa(input logic [PPN_W-1:0] ppn,
                                         input logic [1:0] l,
                                         input logic [W-1:0] va);
    logic [W-1:0] m;
    m = off_mask(l);
    return ({{(W-PPN_W-12){1'b0}}, ppn, 12'b0} & ~m) | (va & m);
  endfunction

  logic [VPN_W-1:0] va_vpn;
  logic [8:0]       vpn_seg;
  logic [W-1:0]     pte_addr;

  assign va_vpn   = virt_addr[12 +: VPN_W];
  assign vpn_seg  = 9'(virt_addr >> (12 + 9 * int'(lvl_q)));
  assign pte_addr = base_q + {{(W-12){1'b0}}, vpn_seg, 3'b000};

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [W-1:0]  hit_pa;

  // First valid TLB entry whose VPN matches above its page size
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && tv_q[i] &&
          (((tvpn_q[i] ^ va_vpn) & vpn_mask(tlvl_q[i])) == '0)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    hit_pa = mk_pa(tppn_q[hit_idx], tlvl_q[hit_idx], virt_addr);
  end

  logic             beat_ok, last_beat, sel_now;
  logic [W-1:0]     pte;
  logic [PPN_W-1:0] pte_ppn;
  logic             pte_bad, pte_leaf, sp_mis, pte_flt;
  logic             unused_pte;

  assign beat_ok   = (state_q == S_WAIT || state_q == S_RESP) &&
                     main_bus_respcyc && (main_bus_resptag == REQ_TAG);
  assign last_beat = beat_q == BW'(LINE_BEATS - 1);
  assign sel_now   = beat_q == pte_addr[3 +: BW];
  assign pte       = (beat_ok && sel_now) ? main_bus_resp : pte_q;
  assign pte_ppn   = pte[53:10];
  assign pte_bad   = !pte[0] || (!pte[1] && pte[2]);
  assign pte_leaf  = pte[1] || pte[3];
  assign sp_mis    = |(pte_ppn &
                       ((PPN_W'(1) << (9 * int'(lvl_q))) - PPN_W'(1)));
  assign pte_flt   = pte_bad || (pte_leaf ? sp_mis : (lvl_q == 2'd0));
  assign unused_pte = ^{pte[63:54], pte[9:4]};

  // Next-state, walk datapath and bus-side outputs
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    pte_d            = pte_q;
    res_d            = res_q;
    lvl_d            = lvl_q;
    beat_d           = beat_q;
    flt_d            = flt_q;
    fill             = 1'b0;
    done             = 1'b0;
    abtr_reqcyc      = 1'b0;
    bus_busy         = 1'b0;
    main_bus_reqcyc  = 1'b0;
    main_bus_req     = '0;
    main_bus_reqtag  = '0;
    main_bus_respack = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          res_d   = hit_pa;
          flt_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          base_d  = ptbr;
          lvl_d   = 2'(LEVELS - 1);
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        abtr_reqcyc = 1'b1;
        if (abtr_grant) state_d = S_REQ;
      end
      S_REQ: begin
        bus_busy        = 1'b1;
        main_bus_reqcyc = 1'b1;
        main_bus_req    = pte_addr & LINE_MASK;
        main_bus_reqtag = REQ_TAG;
        beat_d          = '0;
        state_d         = S_WAIT;
      end
      S_WAIT, S_RESP: begin
        bus_busy         = 1'b1;
        main_bus_respack = beat_ok;
        if (beat_ok) begin
          beat_d  = beat_q + 1'b1;
          pte_d   = pte;
          state_d = S_RESP;
          if (last_beat) begin
            if (pte_flt) begin
              res_d   = '0;
              flt_d   = 1'b1;
              state_d = S_DONE;
            end else if (pte_leaf) begin
              res_d   = mk_pa(pte_ppn, lvl_q, virt_addr);
              flt_d   = 1'b0;
              fill    = 1'b1;
              state_d = S_DONE;
            end else begin
              base_d  = {{(W-PPN_W-12){1'b0}}, pte_ppn, 12'b0};
              lvl_d   = lvl_q - 1'b1;
              state_d = S_ARB;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign phy_addr = done ? res_q : '0;
  assign fault    = done & flt_q;

  // Walk state registers; reset aborts any walk in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      pte_q   <= '0;
      res_q   <= '0;
      lvl_q   <= '0;
      beat_q  <= '0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pte_q   <= pte_d;
      res_q   <= res_d;
      lvl_q   <= lvl_d;
      beat_q  <= beat_d;
      flt_q   <= flt_d;
    end
  end

  // Remember a flush seen during a walk so its result is not cached
  always_ff @(posedge clk) begin
    if (reset || state_q == S_IDLE) flushed_q <= 1'b0;
    else if (flush)                 flushed_q <= 1'b1;
  end

  // TLB fill with round-robin victim; flush beats a same-cycle fill
  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q  <= '0;
      ptr_q <= '0;
    end else if (flush) begin
      tv_q <= '0;
    end else if (fill && !flushed_q) begin
      tv_q[ptr_q]   <= 1'b1;
      tvpn_q[ptr_q] <= va_vpn;
      tlvl_q[ptr_q] <= lvl_q;
      tppn_q[ptr_q] <= pte_ppn;
      ptr_q         <= ptr_q + 1'b1;
    end
  end

`ifdef VAPA_PERF_EN
  logic [31:0] hits_q, miss_q;

  // Saturating hit/miss counters sampled in LOOKUP
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit && hits_q != '1)       hits_q <= hits_q + 32'd1;
      else if (!hit && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign tlb_hits   = hits_q;
  assign tlb_misses = miss_q;
`endif

endmodule
